// File: rtl/aes_ctr_job_sequencer_if.sv
// Bundle of the write-side loads, AES core handshake and output FIFO signals
// seen by the AES-CTR job sequencer. The slave modport is the sequencer's view.
interface aes_ctr_job_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              key_valid;
    logic              nonce_valid;
    logic              pt_valid;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] nonce;
    logic [ADDR_W-1:0] destination;
    logic [DATA_W-1:0] plainText;
    logic              aes_start;
    logic [DATA_W-1:0] aes_key;
    logic [DATA_W-1:0] aes_ctr_block;
    logic              aes_done;
    logic [DATA_W-1:0] aes_keystream;
    logic              fifoFull;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_data;
    logic [ADDR_W-1:0] fifo_addr;
    logic              readWriteReady;
    logic              readWriteError;
    logic [CNT_W-1:0]  blocks_done;

    modport slave (
        input  key_valid, nonce_valid, pt_valid, key, nonce, destination, plainText,
               aes_done, aes_keystream, fifoFull,
        output aes_start, aes_key, aes_ctr_block, fifo_push, fifo_data, fifo_addr,
               readWriteReady, readWriteError, blocks_done
    );

    modport master (
        output key_valid, nonce_valid, pt_valid, key, nonce, destination, plainText,
               aes_done, aes_keystream, fifoFull,
        input  aes_start, aes_key, aes_ctr_block, fifo_push, fifo_data, fifo_addr,
               readWriteReady, readWriteError, blocks_done
    );
endinterface

// File: rtl/aes_ctr_job_sequencer.sv
// AES-CTR job sequencer: latches key/nonce/block loads, starts the AES core,
// XORs the returned keystream with the plaintext and pushes ciphertext plus
// destination into the output FIFO. Owns the block counter (low CTR_W bits of
// the nonce) and a saturating count of pushed blocks.
module aes_ctr_job_sequencer #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input logic                    HCLK,
    input logic                    HRESETn,
    aes_ctr_job_sequencer_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, PUSH} state_t;

    state_t            state;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] ctr_q;
    logic [DATA_W-1:0] pt_q;
    logic [ADDR_W-1:0] dest_q;
    logic              key_loaded;
    logic              nonce_loaded;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              start_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  done_cnt;

    // Key and counter registers feed the core directly; they only change
    // outside RUN, so they are stable for the whole encryption.
    assign bus.aes_key        = key_q;
    assign bus.aes_ctr_block  = ctr_q;
    assign bus.aes_start      = start_q;
    assign bus.fifo_data      = data_q;
    assign bus.fifo_addr      = addr_q;
    assign bus.readWriteError = err_q;
    assign bus.blocks_done    = done_cnt;
    assign bus.readWriteReady = (state == ARMED);
    // Push is a same-cycle handshake with the FIFO so a block can leave one
    // cycle after aes_done; data/addr are registered and held while full.
    assign bus.fifo_push      = (state == PUSH) && !bus.fifoFull;

    // Job sequencing FSM with load latching, counter and block bookkeeping.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= IDLE;
            key_q        <= '0;
            ctr_q        <= '0;
            pt_q         <= '0;
            dest_q       <= '0;
            key_loaded   <= 1'b0;
            nonce_loaded <= 1'b0;
            tmo_cnt      <= '0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
            done_cnt     <= '0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE, ARMED: begin
                    if (bus.key_valid) begin
                        key_q      <= bus.key;
                        key_loaded <= 1'b1;
                    end
                    if (bus.nonce_valid) begin
                        ctr_q        <= bus.nonce;
                        dest_q       <= '0;
                        nonce_loaded <= 1'b1;
                    end
                    if (state == IDLE) begin
                        if (bus.pt_valid)
                            err_q <= 1'b1;
                        if ((key_loaded || bus.key_valid) && (nonce_loaded || bus.nonce_valid))
                            state <= ARMED;
                    end else if (bus.pt_valid) begin
                        // Loads above land on the same edge, so a block
                        // accepted alongside a new key/nonce uses the new values.
                        pt_q    <= bus.plainText;
                        dest_q  <= bus.destination;
                        start_q <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.key_valid || bus.nonce_valid || bus.pt_valid)
                        err_q <= 1'b1;
                    if (bus.aes_done) begin
                        data_q <= pt_q ^ bus.aes_keystream;
                        addr_q <= dest_q;
                        state  <= PUSH;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Core never answered: drop the block, keep the counter.
                        err_q <= 1'b1;
                        state <= ARMED;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                PUSH: begin
                    if (bus.key_valid || bus.nonce_valid || bus.pt_valid)
                        err_q <= 1'b1;
                    if (!bus.fifoFull) begin
                        ctr_q[CTR_W-1:0] <= ctr_q[CTR_W-1:0] + CTR_W'(1);
                        if (done_cnt != {CNT_W{1'b1}})
                            done_cnt <= done_cnt + CNT_W'(1);
                        state <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ctr_job_sequencer.sv
// Directed bench for the AES-CTR job sequencer. Stimulus queues the expected
// FIFO pushes; a negedge monitor pops and compares whenever fifo_push is seen.
module tb_aes_ctr_job_sequencer;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   push_cnt = 0;

    always #5 HCLK = ~HCLK;

    aes_ctr_job_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    aes_ctr_job_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .CTR_W(32), .TIMEOUT(64), .CNT_W(CW)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Scoreboard monitor: every observed push must match the oldest expectation.
    always @(negedge HCLK) begin
        exp_t e;
        if (bus.fifo_push === 1'b1) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_push: data %h addr %h with nothing expected",
                         bus.fifo_data, bus.fifo_addr);
            end else begin
                e = exp_q.pop_front();
                chk("push_data", bus.fifo_data, e.data);
                chk("push_addr", bus.fifo_addr, e.addr);
            end
        end
    end

    // Issue one block from ARMED; core answers after wait_cyc RUN cycles,
    // FIFO stays full for full_cyc cycles once the result is ready.
    task automatic run_block(input logic [DW-1:0] pt, input logic [AW-1:0] dest,
                             input logic [DW-1:0] ks, input logic [DW-1:0] ct,
                             input logic [DW-1:0] exp_ctr, input int wait_cyc,
                             input int full_cyc);
        exp_t e;
        bus.plainText   = pt;
        bus.destination = dest;
        bus.pt_valid    = 1'b1;
        tick();
        bus.pt_valid    = 1'b0;
        bus.key_valid   = 1'b0;
        bus.nonce_valid = 1'b0;
        chk("aes_start_hi", bus.aes_start, 1);
        chk("ctr_block", bus.aes_ctr_block, exp_ctr);
        tick();
        chk("aes_start_lo", bus.aes_start, 0);
        repeat (wait_cyc - 1) tick();
        bus.aes_done      = 1'b1;
        bus.aes_keystream = ks;
        bus.fifoFull      = (full_cyc > 0);
        e.data = ct;
        e.addr = dest;
        exp_q.push_back(e);
        tick();
        bus.aes_done = 1'b0;
        if (full_cyc == 0) chk("push_latency", bus.fifo_push, 1);
        for (int i = 0; i < full_cyc; i++) begin
            chk("push_held", bus.fifo_push, 0);
            chk("data_stable", bus.fifo_data, ct);
            tick();
        end
        bus.fifoFull = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 0; bus.nonce_valid = 0; bus.pt_valid = 0;
        bus.key = '0; bus.nonce = '0; bus.destination = '0; bus.plainText = '0;
        bus.aes_done = 0; bus.aes_keystream = '0; bus.fifoFull = 0;

        // Reset state
        #1;
        chk("rst_push", bus.fifo_push, 0);
        chk("rst_start", bus.aes_start, 0);
        chk("rst_ready", bus.readWriteReady, 0);
        chk("rst_err", bus.readWriteError, 0);
        chk("rst_blocks", bus.blocks_done, 0);
        chk("rst_key", bus.aes_key, 0);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        tick();

        // 1: basic block
        bus.key = 128'h000102030405060708090A0B0C0D0E0F;
        bus.nonce = 128'h1111_2222_3333_4444_5555_6666_0000_0005;
        bus.key_valid = 1; bus.nonce_valid = 1;
        tick();
        bus.key_valid = 0; bus.nonce_valid = 0;
        chk("armed_ready", bus.readWriteReady, 1);
        chk("key_latched", bus.aes_key, 128'h000102030405060708090A0B0C0D0E0F);
        run_block({16{8'h11}}, 32'h1000, {16{8'hFF}}, {16{8'hEE}},
                  128'h1111_2222_3333_4444_5555_6666_0000_0005, 10, 0);
        chk("ctr_inc1", bus.aes_ctr_block, 128'h1111_2222_3333_4444_5555_6666_0000_0006);
        chk("blocks1", bus.blocks_done, 1);

        // 3: FIFO backpressure for 5 cycles
        run_block(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 32'h1010,
                  128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
                  128'hFEDC_4567_7654_CDEF_FFEE_2233_BBAA_6677,
                  128'h1111_2222_3333_4444_5555_6666_0000_0006, 3, 5);
        chk("ctr_inc2", bus.aes_ctr_block, 128'h1111_2222_3333_4444_5555_6666_0000_0007);
        chk("blocks2", bus.blocks_done, 2);

        // aes_done outside RUN is ignored
        bus.aes_done = 1; tick(); bus.aes_done = 0; tick();
        chk("stray_done_ready", bus.readWriteReady, 1);

        // 5: timeout
        bus.pt_valid = 1; tick(); bus.pt_valid = 0;
        chk("tmo_start", bus.aes_start, 1);
        repeat (63) tick();
        chk("tmo_still_run", bus.readWriteReady, 0);
        chk("tmo_no_err_yet", bus.readWriteError, 0);
        tick();
        chk("tmo_err", bus.readWriteError, 1);
        chk("tmo_ready", bus.readWriteReady, 1);
        chk("tmo_ctr", bus.aes_ctr_block, 128'h1111_2222_3333_4444_5555_6666_0000_0007);
        chk("tmo_blocks", bus.blocks_done, 2);
        tick();
        chk("tmo_err_pulse", bus.readWriteError, 0);

        // 4: counter wrap, nonce loaded in the same cycle as the block
        bus.nonce = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF;
        bus.nonce_valid = 1;
        run_block({16{8'h5A}}, 32'h2000, {16{8'hA5}}, {16{8'hFF}},
                  128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_FFFFFFFF, 1, 0);
        chk("ctr_wrap", bus.aes_ctr_block, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_00000000);
        chk("blocks3", bus.blocks_done, 3);

        // 6: reset during PUSH
        bus.plainText = {16{8'h33}}; bus.destination = 32'h3000;
        bus.pt_valid = 1; tick(); bus.pt_valid = 0;
        bus.aes_done = 1; bus.aes_keystream = {16{8'h44}}; bus.fifoFull = 1;
        tick();
        bus.aes_done = 0;
        chk("pre_rst_push", bus.fifo_push, 0);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_push", bus.fifo_push, 0);
        chk("mid_rst_data", bus.fifo_data, 0);
        chk("mid_rst_ctr", bus.aes_ctr_block, 0);
        chk("mid_rst_blocks", bus.blocks_done, 0);
        tick();
        HRESETn = 1'b1;
        bus.fifoFull = 0;
        tick();
        chk("post_rst_ready", bus.readWriteReady, 0);
        chk("post_rst_key", bus.aes_key, 0);

        // 2: block before nonce loaded
        bus.key = {4{32'hDEADBEEF}}; bus.key_valid = 1; tick(); bus.key_valid = 0;
        chk("key_only_ready", bus.readWriteReady, 0);
        bus.pt_valid = 1; tick(); bus.pt_valid = 0;
        chk("early_pt_err", bus.readWriteError, 1);
        chk("early_pt_start", bus.aes_start, 0);
        chk("early_pt_idle", bus.readWriteReady, 0);
        tick();
        chk("early_pt_pulse", bus.readWriteError, 0);
        bus.nonce = 128'h7; bus.nonce_valid = 1; tick(); bus.nonce_valid = 0;
        chk("reload_ready", bus.readWriteReady, 1);
        tick();

        chk("queue_drained", exp_q.size(), 0);
        chk("push_count", push_cnt, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
